ps2_key_rx: RTL

PS2_KEY_RX -- requirements
Module: ps2_key_rx

---
 rtl/ps2_key_rx_if.sv | 10 +
 rtl/ps2_key_rx.sv | 129 ++++++++++++
 2 files changed

// File: rtl/ps2_key_rx_if.sv
// ps2_key_rx_if: PS/2 pad inputs and decoded key-event outputs of the receiver.
interface ps2_key_rx_if;
   logic        ps2_clk;
   logic        ps2_dat;
   logic [10:0] ps2_key;
   logic        key_strobe;
   logic        frame_err;
   modport master (output ps2_clk, ps2_dat, input ps2_key, key_strobe, frame_err);
   modport slave  (input ps2_clk, ps2_dat, output ps2_key, key_strobe, frame_err);
endinterface

// File: rtl/ps2_key_rx.sv
// ps2_key_rx: PS/2 keyboard frame receiver with clock filtering, scancode prefix decode and timeout.
module ps2_key_rx #(
   parameter int FILT    = 8,
   parameter int TIMEOUT = 50000
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   ps2_key_rx_if.slave bus
);
   localparam int FW = $clog2(FILT + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   state_t        state_q, state_d;
   logic [1:0]    clk_s_q, clk_s_d, dat_s_q, dat_s_d;
   logic          clk_f_q, clk_f_d;
   logic [FW-1:0] filt_cnt_q, filt_cnt_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d, skip_q, skip_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d, ext_q, ext_d, rel_q, rel_d;
   logic [10:0]   key_q, key_d;
   logic          strobe_q, strobe_d, err_q, err_d;
   logic          flip, fall, dat;
   always_comb begin
      clk_s_d    = {clk_s_q[0], bus.ps2_clk};
      dat_s_d    = {dat_s_q[0], bus.ps2_dat};
      flip       = (clk_s_q[1] != clk_f_q) && (filt_cnt_q == FW'(FILT - 1));
      clk_f_d    = flip ? clk_s_q[1] : clk_f_q;
      filt_cnt_d = (clk_s_q[1] == clk_f_q || flip) ? '0 : filt_cnt_q + FW'(1);
      fall       = flip && !clk_s_q[1];
      dat        = dat_s_q[1];
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_d      = par_q;
      ext_d      = ext_q;
      rel_d      = rel_q;
      skip_d     = skip_q;
      key_d      = key_q;
      strobe_d   = 1'b0;
      err_d      = 1'b0;
      to_cnt_d   = (state_q == IDLE || fall) ? '0 : to_cnt_q + TW'(1);
      if (fall) begin
         case (state_q)
            IDLE: begin
               state_d   = dat ? IDLE : DATA;
               bit_cnt_d = '0;
            end
            DATA: begin
               shift_d   = {dat, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               state_d   = (bit_cnt_q == 3'd7) ? PARITY : DATA;
            end
            PARITY: begin
               par_d   = dat;
               state_d = STOP;
            end
            STOP: begin
               state_d = IDLE;
               if (!dat || !(^{shift_q, par_q})) begin
                  err_d  = 1'b1;
                  ext_d  = 1'b0;
                  rel_d  = 1'b0;
                  skip_d = '0;
               end else if (skip_q != '0) begin
                  skip_d = skip_q - 3'd1;
               end else if (shift_q == 8'hE1) begin
                  skip_d = 3'd7;
               end else if (shift_q == 8'hE0) begin
                  ext_d = 1'b1;
               end else if (shift_q == 8'hF0) begin
                  rel_d = 1'b1;
               end else begin
                  key_d    = {~key_q[10], ~rel_q, ext_q, shift_q};
                  strobe_d = 1'b1;
                  ext_d    = 1'b0;
                  rel_d    = 1'b0;
               end
            end
         endcase
      end else if (state_q != IDLE && to_cnt_q == TW'(TIMEOUT - 1)) begin
         state_d  = IDLE;
         err_d    = 1'b1;
         ext_d    = 1'b0;
         rel_d    = 1'b0;
         skip_d   = '0;
         to_cnt_d = '0;
      end
   end
   // Pads idle high, so synchronizers and filter reset to 1 to avoid a spurious edge.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         clk_s_q    <= 2'b11;
         dat_s_q    <= 2'b11;
         clk_f_q    <= 1'b1;
         filt_cnt_q <= '0;
         to_cnt_q   <= '0;
         bit_cnt_q  <= '0;
         skip_q     <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         ext_q      <= 1'b0;
         rel_q      <= 1'b0;
         key_q      <= '0;
         strobe_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         clk_s_q    <= clk_s_d;
         dat_s_q    <= dat_s_d;
         clk_f_q    <= clk_f_d;
         filt_cnt_q <= filt_cnt_d;
         to_cnt_q   <= to_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         skip_q     <= skip_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         ext_q      <= ext_d;
         rel_q      <= rel_d;
         key_q      <= key_d;
         strobe_q   <= strobe_d;
         err_q      <= err_d;
      end
   end
   assign bus.ps2_key    = key_q;
   assign bus.key_strobe = strobe_q;
   assign bus.frame_err  = err_q;
endmodule
